// File: rtl/agc_chan_pkg.sv
// Shared constants and channel-address decode for the AGC input channel bank.
package agc_chan_pkg;

  localparam int CH_ADDR_W = 7;
  localparam int DB_CNT_W  = 4;

  typedef struct packed {
    logic                 hit;
    logic [CH_ADDR_W-1:0] idx;
  } chan_sel_t;

  // Offset of addr from base, with hit set only when base <= addr < base+nchan.
  function automatic chan_sel_t chan_index(input logic [CH_ADDR_W-1:0] addr,
                                           input logic [CH_ADDR_W-1:0] base,
                                           input logic [CH_ADDR_W:0]   nchan);
    chan_sel_t sel;
    sel.idx = addr - base;
    sel.hit = (addr >= base) && ({1'b0, sel.idx} < nchan);
    return sel;
  endfunction

endpackage

// File: rtl/agc_debounce_bit.sv
// One discrete: two-flop synchroniser, tick-driven debounce counter, filtered
// level and a registered one-cycle pulse whenever the filtered level moves.
module agc_debounce_bit
  import agc_chan_pkg::*;
#(
  parameter int   DEBOUNCE  = 3,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic CLOCK,
  input  logic rst,
  input  logic sample_tick,
  input  logic in_raw,
  output logic filt,
  output logic change
);

  logic                sync1_q, sync2_q;
  logic                filt_q, filt_d;
  logic                change_q, change_d;
  logic [DB_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d    = cnt_q;
    filt_d   = filt_q;
    change_d = 1'b0;
    if (sample_tick) begin
      if (sync2_q != filt_q) begin
        if (cnt_q + 1'b1 == DB_CNT_W'(DEBOUNCE)) begin
          filt_d   = sync2_q;
          cnt_d    = '0;
          change_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge CLOCK or negedge rst) begin
    if (!rst) begin
      sync1_q  <= RESET_VAL;
      sync2_q  <= RESET_VAL;
      filt_q   <= RESET_VAL;
      change_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= in_raw;
      sync2_q  <= sync1_q;
      filt_q   <= filt_d;
      change_q <= change_d;
      cnt_q    <= cnt_d;
    end
  end

  assign filt   = filt_q;
  assign change = change_q;

endmodule

// File: rtl/agc_input_channel_bank.sv
// Bank of debounced input channels served onto the active-low CHOR_ read bus,
// with sticky per-bit change flags feeding a single maskable interrupt.
module agc_input_channel_bank
  import agc_chan_pkg::*;
#(
  parameter int                   NCHAN     = 4,
  parameter int                   WIDTH     = 15,
  parameter logic [CH_ADDR_W-1:0] BASE_CH   = 7'o30,
  parameter int                   DEBOUNCE  = 3,
  parameter logic [NCHAN*WIDTH-1:0] RESET_VAL = '1
) (
  input  logic                   CLOCK,
  input  logic                   rst,
  input  logic                   sample_tick,
  input  logic [NCHAN*WIDTH-1:0] in_raw,
  input  logic [NCHAN*WIDTH-1:0] irq_en,
  input  logic                   rd_en,
  input  logic [CH_ADDR_W-1:0]   rd_ch,
  output logic [WIDTH-1:0]       CHOR_,
  output logic                   rd_hit,
  output logic                   irq_req,
  input  logic                   irq_ack,
  output logic [NCHAN*WIDTH-1:0] filt
);

  localparam int NBITS = NCHAN * WIDTH;
  localparam int IDX_W = (NCHAN > 1) ? $clog2(NCHAN) : 1;

  if (int'(BASE_CH) + NCHAN > 128) begin : g_bad_range
    $error("agc_input_channel_bank: BASE_CH+NCHAN exceeds the 7-bit channel space");
  end
  if (DEBOUNCE < 1 || DEBOUNCE > 15) begin : g_bad_debounce
    $error("agc_input_channel_bank: DEBOUNCE must lie in 1..15");
  end

  logic [NBITS-1:0] change;
  logic [NBITS-1:0] pending_q, pending_d;
  logic [WIDTH-1:0] chan_word [NCHAN];
  logic [WIDTH-1:0] chor_q, chor_d;
  logic             rd_hit_q, rd_hit_d;
  chan_sel_t        sel;

  genvar gi;
  for (gi = 0; gi < NBITS; gi++) begin : g_bit
    agc_debounce_bit #(
      .DEBOUNCE  (DEBOUNCE),
      .RESET_VAL (RESET_VAL[gi])
    ) u_bit (
      .CLOCK       (CLOCK),
      .rst         (rst),
      .sample_tick (sample_tick),
      .in_raw      (in_raw[gi]),
      .filt        (filt[gi]),
      .change      (change[gi])
    );
  end

  for (gi = 0; gi < NCHAN; gi++) begin : g_word
    assign chan_word[gi] = filt[gi*WIDTH +: WIDTH];
  end

  // A change arriving alongside irq_ack survives: the OR is applied after the clear.
  assign pending_d = (pending_q & ~{NBITS{irq_ack}}) | (change & irq_en);

  always_comb begin
    sel      = chan_index(rd_ch, BASE_CH, (CH_ADDR_W+1)'(NCHAN));
    chor_d   = '1;
    rd_hit_d = 1'b0;
    if (rd_en && sel.hit) begin
      chor_d   = ~chan_word[sel.idx[IDX_W-1:0]];
      rd_hit_d = 1'b1;
    end
  end

  always_ff @(posedge CLOCK or negedge rst) begin
    if (!rst) begin
      pending_q <= '0;
      chor_q    <= '1;
      rd_hit_q  <= 1'b0;
    end else begin
      pending_q <= pending_d;
      chor_q    <= chor_d;
      rd_hit_q  <= rd_hit_d;
    end
  end

  assign CHOR_   = chor_q;
  assign rd_hit  = rd_hit_q;
  assign irq_req = |pending_q;

endmodule

// File: doc/agc_input_channel_bank.md
# agc_input_channel_bank

Parametrised successor to the fixed-width discrete-input logic of module A17. It samples NCHAN input channels of WIDTH discretes each, synchronises and debounces every bit, and serves them onto the active-low channel read bus (CHOR_) for I/O channel reads. It also raises a sticky, maskable change interrupt, a generalised HNDRPT. It sits between the raw spacecraft discretes and the channel read-bus OR tree.

## Interface
Parameters:
- NCHAN, 4: number of input channels served
- WIDTH, 15: discretes per channel, bits 1..WIDTH
- BASE_CH, 7'o30: channel address of channel index 0
- DEBOUNCE, 3: consecutive agreeing sample ticks required to accept a new level (1..15)
- RESET_VAL, all-ones: per-bit filtered value after reset, packed NCHAN*WIDTH

Ports:
- CLOCK  in  1  single system clock
- rst  in  1  asynchronous, active-low reset
- sample_tick  in  1  one-cycle debounce sampling strobe (F05-rate)
- in_raw  in  NCHAN*WIDTH  asynchronous raw discretes; channel c bit b at c*WIDTH+b-1
- irq_en  in  NCHAN*WIDTH  per-bit change-interrupt enable
- rd_en  in  1  channel read strobe
- rd_ch  in  7  channel address for the read
- CHOR_  out  WIDTH  active-low read data; all-ones when idle or not addressed
- rd_hit  out  1  registered; the last read addressed this bank
- irq_req  out  1  change interrupt pending
- irq_ack  in  1  clears all pending change flags
- filt  out  NCHAN*WIDTH  debounced values, for monitor and relay logic

## Operation
- Per bit: a two-flop synchroniser feeds a debounce filter.
- Filter: on each sample_tick, if the synchronised value differs from filt, increment a 4-bit counter; otherwise clear it. When the counter reaches DEBOUNCE, filt takes the synchronised value and the counter clears. Without sample_tick the counter holds.
- Change detect: a filt update on a bit whose irq_en is 1 sets that bit's pending flag. irq_req is the OR of all pending flags.
- irq_ack clears all pending flags. If a new change lands in the same cycle as irq_ack, the new change wins and its flag stays set.
- Read, hit case: rd_en with BASE_CH <= rd_ch < BASE_CH+NCHAN. On the next edge, CHOR_ <= ~filt of channel (rd_ch-BASE_CH) and rd_hit <= 1.
- Read, miss case: any other address, or rd_en low. On the next edge, CHOR_ <= all-ones and rd_hit <= 0.
- Address arithmetic is 7-bit unsigned. BASE_CH+NCHAN must not exceed 128; this is checked at elaboration.

## Timing
- Reset values (asynchronous, on rst low): synchroniser flops = RESET_VAL; filt = RESET_VAL; counters 0; pending 0; irq_req 0; CHOR_ all-ones; rd_hit 0.
- Input to filt latency: 2 cycles of synchronisation, then DEBOUNCE sample_ticks. filt updates on the edge of the DEBOUNCE-th agreeing tick.
- filt to irq_req: 1 cycle, as a registered flag.
- Read latency: 1 cycle. CHOR_ holds for exactly one cycle per rd_en, then returns to all-ones.
- A read concurrent with a filt update returns the pre-update value.
- A glitch shorter than DEBOUNCE ticks resets the counter and never reaches filt.
- Reset mid-debounce discards partial counts. Reset with irq pending clears it. No spurious irq on reset release, because filt already equals RESET_VAL.

## Structure
- Shared package agc_chan_pkg holds:
  - localparam CH_ADDR_W = 7
  - function chan_index(addr, base) with a range check
  - the DEBOUNCE counter width constant
- Sub-module agc_debounce_bit (synchroniser + counter + filt bit + change pulse) is generated NCHAN*WIDTH times.
- The top level holds the pending flags, the irq OR and the read mux/register.

## Test plan
- Reset: hold rst low with in_raw toggling -> CHOR_=15'h7FFF, irq_req=0, filt=RESET_VAL. Release, idle 10 cycles -> irq_req stays 0.
- Debounce: DEBOUNCE=3; drop channel 0 bit 1 to 0, tick every 4 cycles -> filt bit changes on the 3rd tick after sync, not before. Then a 2-tick pulse on bit 2 -> no change.
- Read mux: set channel 2 filt=15'h1234, rd_en with rd_ch=7'o32 -> next cycle CHOR_=15'h6DCB, rd_hit=1. Then rd_ch=7'o34 -> CHOR_=7FFF, rd_hit=0.
- Interrupt: irq_en only on channel 1 bit 5. A change on channel 1 bit 4 -> no irq. A change on channel 1 bit 5 -> irq_req=1 one cycle after the filt update. irq_ack -> 0.
- Simultaneous: irq_ack in the same cycle as a new enabled change -> irq_req remains 1. A second irq_ack clears it.
- Reset mid-operation: assert rst at DEBOUNCE-1 ticks with irq pending -> all outputs return to reset values immediately. The counter restarts from 0 after release.
